uncache_axi_bridge: RTL and testbench

//  Single-beat AXI4 master that executes the uncached access captured by the uncache tag stage.

---
 rtl/uncache_axi_bridge.sv | 234 +++++++++++++++++++++++
 tb/tb_uncache_axi_bridge.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_axi_bridge.sv
// Single-beat AXI4 master for the uncached access held by the tag stage; registered refresh 3 edges after accept at best.
// Every valid is held until its handshake, and bready/rready are raised only once the request side has completed.
module uncache_axi_bridge #(
    parameter int unsigned     ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            resetn,

    // request from the uncache tag stage
    input  logic            axi_en,
    input  logic [3:0]      axi_wsel,
    input  logic [31:0]     axi_addr,
    input  logic [31:0]     axi_wdata,
    output logic [31:0]     axi_rdata,
    output logic            refresh,
    output logic            resp_err,

    // AR channel
    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,

    // R channel
    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    // AW channel
    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awlock,
    output logic [3:0]      awcache,
    output logic [2:0]      awprot,
    output logic            awvalid,
    input  logic            awready,

    // W channel
    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,

    // B channel
    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_AW,
        WR_B,
        DONE
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [3:0]  strb_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        arvalid_q;
    logic        rready_q;
    logic        awvalid_q;
    logic        wvalid_q;
    logic        bready_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        refresh_q;
    logic        resp_err_q;

    logic        aw_hs;
    logic        w_hs;
    logic        aw_ok;
    logic        w_ok;
    logic [2:0]  awsize_c;

    // IDs of responses are not checked: only one transaction is ever outstanding
    logic        unused_rsp;
    assign unused_rsp = ^{rid, rlast, bid};

    assign aw_hs = awvalid_q & awready;
    assign w_hs  = wvalid_q & wready;
    assign aw_ok = aw_done_q | aw_hs;
    assign w_ok  = w_done_q | w_hs;

    // Narrowest size that covers the strobe; scattered patterns fall back to a full word
    always_comb begin
        awsize_c = 3'b010;
        case (strb_q)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: awsize_c = 3'b000;
            4'b0011, 4'b1100:                   awsize_c = 3'b001;
            default:                            awsize_c = 3'b010;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            strb_q     <= 4'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            refresh_q  <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            refresh_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (axi_en) begin
                        addr_q     <= axi_addr;
                        strb_q     <= axi_wsel;
                        wdata_q    <= axi_wdata;
                        resp_err_q <= 1'b0;
                        aw_done_q  <= 1'b0;
                        w_done_q   <= 1'b0;
                        if (axi_wsel == 4'b0000) begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_A;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_AW;
                        end
                    end
                end
                RD_A: begin
                    if (arvalid_q && arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_D;
                    end
                end
                RD_D: begin
                    if (rvalid && rready_q) begin
                        rdata_q    <= rdata;
                        resp_err_q <= |rresp;
                        rready_q   <= 1'b0;
                        refresh_q  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                WR_AW: begin
                    // AW and W complete independently; the done flags stop re-issue
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_ok && w_ok) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_B;
                    end
                end
                WR_B: begin
                    if (bvalid && bready_q) begin
                        resp_err_q <= |bresp;
                        bready_q   <= 1'b0;
                        refresh_q  <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    // axi_en is still high here; the tag stage drops it on this edge
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign axi_rdata = rdata_q;
    assign refresh   = refresh_q;
    assign resp_err  = resp_err_q;

    assign arid      = AXI_ID;
    assign araddr    = addr_q;
    assign arlen     = 8'd0;
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign arlock    = 1'b0;
    assign arcache   = 4'd0;
    assign arprot    = 3'd0;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;

    assign awid      = AXI_ID;
    assign awaddr    = addr_q;
    assign awlen     = 8'd0;
    assign awsize    = awsize_c;
    assign awburst   = 2'b01;
    assign awlock    = 1'b0;
    assign awcache   = 4'd0;
    assign awprot    = 3'd0;
    assign awvalid   = awvalid_q;

    assign wid       = AXI_ID;
    assign wdata     = wdata_q;
    assign wstrb     = strb_q;
    assign wlast     = 1'b1;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;

endmodule

// File: tb/tb_uncache_axi_bridge.sv
// Randomized bench for uncache_axi_bridge: a cycle-driven AXI slave plus a latency/response model.
module tb_uncache_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        axi_en;
    logic [3:0]  axi_wsel;
    logic [31:0] axi_addr;
    logic [31:0] axi_wdata;
    logic [31:0] axi_rdata;
    logic        refresh;
    logic        resp_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] exp_rdata;
    logic        exp_err;

    always #5 clk = ~clk;

    uncache_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .axi_en(axi_en), .axi_wsel(axi_wsel), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
        .axi_rdata(axi_rdata), .refresh(refresh), .resp_err(resp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Transfer size implied by a byte strobe: one byte, an aligned halfword, else a word
    function automatic logic [2:0] exp_size(input logic [3:0] s);
        if ($countones(s) == 1) return 3'd0;
        if (s == 4'b0011 || s == 4'b1100) return 3'd1;
        return 3'd2;
    endfunction

    task automatic slave_idle();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid  = 1'b0; bvalid  = 1'b0;
        rdata   = 32'd0; rresp = 2'd0; bresp = 2'd0;
    endtask

    // One transaction from accept to four idle cycles after refresh.
    // da: cycles the address channel is held not-ready, dw: same for W,
    // dr: cycles between request completion and the response valid.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] rsp,
                           input int da, input int dw, input int dr);
        int n = 0, n_a = -1, n_w = -1, ref_n = -1, refs = 0, viol = 0, exp_lat;
        int c_ar = 0, c_r = 0, c_aw = 0, c_w = 0, c_b = 0;
        bit ar_pend = 0, aw_pend = 0, w_pend = 0;
        logic [31:0] p_araddr = 0, p_awaddr = 0, p_wdata = 0, got_rdata = 0;
        logic [3:0]  p_wstrb = 0;
        logic [2:0]  p_awsize = 0;
        logic        got_err = 0;

        axi_en    = 1'b1;
        axi_addr  = addr;
        axi_wsel  = wr ? sel : 4'd0;
        axi_wdata = wd;
        while (n < 300 && !(ref_n >= 0 && n >= ref_n + 4)) begin
            @(posedge clk); #1;
            n++;
            if (ar_pend && (!arvalid || araddr != p_araddr)) viol++;
            if (aw_pend && (!awvalid || awaddr != p_awaddr || awsize != p_awsize)) viol++;
            if (w_pend && (!wvalid || wdata != p_wdata || wstrb != p_wstrb || !wlast)) viol++;
            if (rready && c_ar == 0) viol++;
            if (bready && (c_aw == 0 || c_w == 0)) viol++;
            if (refresh) begin
                refs++;
                if (ref_n < 0) begin
                    ref_n     = n;
                    got_rdata = axi_rdata;
                    got_err   = resp_err;
                end
            end
            if (ref_n >= 0 && n == ref_n + 1) axi_en = 1'b0;

            arready = (n > da);
            awready = (n > da);
            wready  = (n > dw);
            rvalid  = !wr && n_a >= 0 && c_r == 0 && (n - n_a > dr);
            bvalid  = wr && n_a >= 0 && n_w >= 0 && c_b == 0 &&
                      (n - ((n_a > n_w) ? n_a : n_w) > dr);
            rdata   = rd;
            rresp   = rsp;
            bresp   = rsp;

            if (arvalid && arready) begin
                c_ar++; n_a = n;
                chk("araddr", araddr, addr);
                chk("ar_attr", 32'({arid, arlen, arsize, arburst, arlock, arcache, arprot}),
                    32'({4'd1, 8'd0, 3'd2, 2'd1, 1'b0, 4'd0, 3'd0}));
            end
            if (awvalid && awready) begin
                c_aw++; n_a = n;
                chk("awaddr", awaddr, addr);
                chk("aw_attr", 32'({awid, awlen, awsize, awburst, awlock, awcache, awprot}),
                    32'({4'd1, 8'd0, exp_size(sel), 2'd1, 1'b0, 4'd0, 3'd0}));
            end
            if (wvalid && wready) begin
                c_w++; n_w = n;
                chk("wdata", wdata, wd);
                chk("w_attr", 32'({wid, wstrb, wlast}), 32'({4'd1, sel, 1'b1}));
            end
            if (rvalid && rready) c_r++;
            if (bvalid && bready) c_b++;
            ar_pend = arvalid && !arready;  p_araddr = araddr;
            aw_pend = awvalid && !awready;  p_awaddr = awaddr; p_awsize = awsize;
            w_pend  = wvalid && !wready;    p_wdata  = wdata;  p_wstrb  = wstrb;
        end
        axi_en = 1'b0;
        slave_idle();

        if (!wr) exp_rdata = rd;
        exp_err = (rsp != 2'b00);
        exp_lat = wr ? (((da > dw) ? da : dw) + 3 + dr) : (da + 3 + dr);

        chk("refresh_cnt", 32'(refs), 32'd1);
        chk("latency", 32'(ref_n), 32'(exp_lat));
        chk("hs_counts", 32'({c_ar[3:0], c_r[3:0], c_aw[3:0], c_w[3:0], c_b[3:0]}),
            wr ? 32'h00111 : 32'h11000);
        chk("protocol_viol", 32'(viol), 32'd0);
        chk("rdata_at_refresh", got_rdata, exp_rdata);
        chk("err_at_refresh", 32'(got_err), 32'(exp_err));
        chk("err_held", 32'(resp_err), 32'(exp_err));
        chk("rdata_held", axi_rdata, exp_rdata);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit          seen;
        bit          wr;
        logic [3:0]  sel;
        logic [1:0]  rsp;

        resetn = 1'b0;
        axi_en = 1'b0; axi_wsel = 4'd0; axi_addr = 32'd0; axi_wdata = 32'd0;
        rid = 4'd0; bid = 4'd0; rlast = 1'b1;
        slave_idle();
        exp_rdata = 32'd0;
        exp_err   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        chk("rst_refresh", 32'(refresh), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_axi_rdata", axi_rdata, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_wstrb", 32'(wstrb), 32'd0);
        resetn = 1'b1;
        @(posedge clk); #1;

        run_txn(1'b0, 32'hBFD0_03F8, 4'd0,    32'd0,        32'h0000_0041, 2'b00, 0, 0, 2);
        run_txn(1'b1, 32'hBFAF_F002, 4'b0100, 32'h00AB_0000, 32'd0,        2'b00, 0, 0, 0);
        run_txn(1'b1, 32'h1000_0010, 4'b1111, 32'hDEAD_BEEF, 32'd0,        2'b00, 0, 4, 0);
        run_txn(1'b1, 32'h1000_0020, 4'b0011, 32'h0000_1234, 32'd0,        2'b00, 4, 0, 1);
        run_txn(1'b0, 32'h2000_0004, 4'd0,    32'd0,        32'hCAFE_F00D, 2'b00, 10, 0, 0);
        run_txn(1'b1, 32'h3000_0000, 4'b1100, 32'h5566_0000, 32'd0,        2'b10, 1, 1, 0);
        run_txn(1'b0, 32'h3000_0008, 4'd0,    32'd0,        32'h0BAD_0BAD, 2'b11, 0, 0, 0);

        // Reset while waiting for read data
        axi_en = 1'b1; axi_wsel = 4'd0; axi_addr = 32'h4000_0000; arready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk); #1;
            if (rready) seen = 1'b1;
        end
        chk("rst_reach_rd_d", 32'(seen), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_valids", 32'({arvalid, rready, awvalid, wvalid, bready}), 32'd0);
        chk("rst_mid_refresh", 32'(refresh), 32'd0);
        arready = 1'b0; axi_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_hold_refresh", 32'(refresh), 32'd0);
        end
        resetn = 1'b1;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_idle", 32'({arvalid, rready, refresh}), 32'd0);
        chk("post_rst_rdata", axi_rdata, 32'd0);
        run_txn(1'b0, 32'h4000_0000, 4'd0, 32'd0, 32'h1357_9BDF, 2'b00, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            wr  = 1'($urandom_range(0, 1));
            sel = wr ? 4'($urandom_range(1, 15)) : 4'd0;
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(wr, $urandom, sel, $urandom, $urandom, rsp,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
